// File: rtl/mod_ppu_pkg.sv
// Shared PPU definitions: CPU register indices, NTSC/PAL frame geometry and the
// bit layout of the loopy v/t scroll registers, plus the v increment helpers.
package mod_ppu_pkg;

  localparam logic [2:0] REG_PPUCTRL   = 3'd0;
  localparam logic [2:0] REG_PPUMASK   = 3'd1;
  localparam logic [2:0] REG_PPUSTATUS = 3'd2;
  localparam logic [2:0] REG_OAMADDR   = 3'd3;
  localparam logic [2:0] REG_OAMDATA   = 3'd4;
  localparam logic [2:0] REG_PPUSCROLL = 3'd5;
  localparam logic [2:0] REG_PPUADDR   = 3'd6;
  localparam logic [2:0] REG_PPUDATA   = 3'd7;

  localparam int NTSC_DOTS_PER_LINE   = 341;
  localparam int NTSC_LINES_PER_FRAME = 262;
  localparam int PAL_LINES_PER_FRAME  = 312;
  localparam int NTSC_VBLANK_LINE     = 241;
  localparam int VISIBLE_LINES        = 240;

  localparam int V_W          = 15;
  localparam int COARSE_X_LSB = 0;
  localparam int COARSE_X_MSB = 4;
  localparam int COARSE_Y_LSB = 5;
  localparam int COARSE_Y_MSB = 9;
  localparam int NT_X_BIT     = 10;
  localparam int NT_Y_BIT     = 11;
  localparam int FINE_Y_LSB   = 12;
  localparam int FINE_Y_MSB   = 14;
  localparam int ADDR_LO_MSB  = 7;
  localparam int ADDR_HI_LSB  = 8;
  localparam int ADDR_HI_MSB  = 13;

  typedef logic [V_W-1:0] vaddr_t;

  // Horizontal tile step: coarse X wraps into the neighbouring horizontal nametable.
  function automatic vaddr_t inc_coarse_x(input vaddr_t v);
    vaddr_t r;
    r = v;
    if (v[COARSE_X_MSB:COARSE_X_LSB] == 5'd31) begin
      r[COARSE_X_MSB:COARSE_X_LSB] = 5'd0;
      r[NT_X_BIT]                  = ~v[NT_X_BIT];
    end else begin
      r[COARSE_X_MSB:COARSE_X_LSB] = v[COARSE_X_MSB:COARSE_X_LSB] + 5'd1;
    end
    return r;
  endfunction

  // Vertical pixel step: row 29 is the last tile row of a nametable, rows 30/31
  // are attribute space and wrap without switching nametables.
  function automatic vaddr_t inc_fine_y(input vaddr_t v);
    vaddr_t r;
    r = v;
    if (v[FINE_Y_MSB:FINE_Y_LSB] != 3'd7) begin
      r[FINE_Y_MSB:FINE_Y_LSB] = v[FINE_Y_MSB:FINE_Y_LSB] + 3'd1;
    end else begin
      r[FINE_Y_MSB:FINE_Y_LSB] = 3'd0;
      if (v[COARSE_Y_MSB:COARSE_Y_LSB] == 5'd29) begin
        r[COARSE_Y_MSB:COARSE_Y_LSB] = 5'd0;
        r[NT_Y_BIT]                  = ~v[NT_Y_BIT];
      end else if (v[COARSE_Y_MSB:COARSE_Y_LSB] == 5'd31) begin
        r[COARSE_Y_MSB:COARSE_Y_LSB] = 5'd0;
      end else begin
        r[COARSE_Y_MSB:COARSE_Y_LSB] = v[COARSE_Y_MSB:COARSE_Y_LSB] + 5'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_ppu_video_timing.sv
// Beam position counter (dot, scanline) with frame parity and the odd-frame
// short pre-render line.
module mod_ppu_video_timing
  import mod_ppu_pkg::*;
#(
  parameter int DOTS_PER_LINE   = NTSC_DOTS_PER_LINE,
  parameter int LINES_PER_FRAME = NTSC_LINES_PER_FRAME,
  parameter int ODD_FRAME_SKIP  = 1
) (
  input  logic       in_ppu_pixel_clk,
  input  logic       in_rst_n,
  input  logic       in_rendering_en,
  output logic [8:0] out_dot,
  output logic [8:0] out_scanline,
  output logic       out_frame_odd
);

  localparam logic [8:0] LAST_DOT = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] SKIP_DOT = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] PRE_LINE = 9'(LINES_PER_FRAME - 1);
  localparam logic       SKIP_EN  = (ODD_FRAME_SKIP != 0);

  logic [8:0] dot_q, dot_d;
  logic [8:0] line_q, line_d;
  logic       odd_q, odd_d;
  logic       skip;

  always_comb begin
    skip   = SKIP_EN && odd_q && in_rendering_en &&
             (line_q == PRE_LINE) && (dot_q == SKIP_DOT);
    dot_d  = dot_q + 9'd1;
    line_d = line_q;
    odd_d  = odd_q;
    // The skip jumps straight to (0,0), so it also counts as a frame wrap.
    if (skip || (dot_q == LAST_DOT)) begin
      dot_d = 9'd0;
      if (skip || (line_q == PRE_LINE)) begin
        line_d = 9'd0;
        odd_d  = ~odd_q;
      end else begin
        line_d = line_q + 9'd1;
      end
    end
  end

  always_ff @(posedge in_ppu_pixel_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      dot_q  <= 9'd0;
      line_q <= 9'd0;
      odd_q  <= 1'b0;
    end else begin
      dot_q  <= dot_d;
      line_q <= line_d;
      odd_q  <= odd_d;
    end
  end

  assign out_dot       = dot_q;
  assign out_scanline  = line_q;
  assign out_frame_odd = odd_q;

endmodule

// File: rtl/mod_ppu_scroll_timing.sv
// PPU scroll register file (v, t, x, w) driven by CPU register accesses and by
// the rendering-time increments/copies, plus vblank flag generation.
module mod_ppu_scroll_timing
  import mod_ppu_pkg::*;
#(
  parameter int DOTS_PER_LINE   = NTSC_DOTS_PER_LINE,
  parameter int LINES_PER_FRAME = NTSC_LINES_PER_FRAME,
  parameter int VBLANK_LINE     = NTSC_VBLANK_LINE,
  parameter int ODD_FRAME_SKIP  = 1
) (
  input  logic        in_ppu_pixel_clk,
  input  logic        in_rst_n,
  input  logic        in_reg_wr,
  input  logic        in_reg_rd,
  input  logic [2:0]  in_reg_addr,
  input  logic [7:0]  in_reg_wdata,
  input  logic        in_rendering_en,
  output logic [8:0]  out_dot,
  output logic [8:0]  out_scanline,
  output logic [14:0] out_vram_addr,
  output logic [14:0] out_vram_addr_temp,
  output logic [2:0]  out_fine_x,
  output logic        out_w,
  output logic        out_vblank,
  output logic        out_vblank_start,
  output logic        out_frame_odd
);

  localparam logic [8:0] PRE_LINE = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VBL_LINE = 9'(VBLANK_LINE);
  localparam logic [8:0] VIS_END  = 9'(VISIBLE_LINES);

  logic [8:0] dot;
  logic [8:0] scanline;
  logic       frame_odd;

  mod_ppu_video_timing #(
    .DOTS_PER_LINE   (DOTS_PER_LINE),
    .LINES_PER_FRAME (LINES_PER_FRAME),
    .ODD_FRAME_SKIP  (ODD_FRAME_SKIP)
  ) u_video_timing (
    .in_ppu_pixel_clk (in_ppu_pixel_clk),
    .in_rst_n         (in_rst_n),
    .in_rendering_en  (in_rendering_en),
    .out_dot          (dot),
    .out_scanline     (scanline),
    .out_frame_odd    (frame_odd)
  );

  vaddr_t     v_q, v_d;
  vaddr_t     t_q, t_d;
  logic [2:0] x_q, x_d;
  logic       w_q, w_d;
  logic       inc32_q, inc32_d;
  logic       vblank_q, vblank_d;

  logic on_pre;
  logic render_active;
  logic evt_cx, evt_y, evt_hcopy, evt_vcopy;
  logic data_acc;
  logic load_v;

  // Rendering-time events on v, decoded from the current beam position.
  always_comb begin
    on_pre        = (scanline == PRE_LINE);
    render_active = in_rendering_en && ((scanline < VIS_END) || on_pre);
    evt_cx        = render_active &&
                    (((dot != 9'd0) && (dot <= 9'd256) && (dot[2:0] == 3'd0)) ||
                     (dot == 9'd328) || (dot == 9'd336));
    evt_y         = render_active && (dot == 9'd256);
    evt_hcopy     = render_active && (dot == 9'd257);
    evt_vcopy     = render_active && on_pre && (dot >= 9'd280) && (dot <= 9'd304);
    data_acc      = (in_reg_addr == REG_PPUDATA) && (in_reg_wr || in_reg_rd);
  end

  // CPU register effects on t, x, w and the control increment mode.
  always_comb begin
    t_d     = t_q;
    x_d     = x_q;
    w_d     = w_q;
    inc32_d = inc32_q;
    load_v  = 1'b0;
    if (in_reg_wr) begin
      case (in_reg_addr)
        REG_PPUCTRL: begin
          t_d[NT_Y_BIT:NT_X_BIT] = in_reg_wdata[1:0];
          inc32_d                = in_reg_wdata[2];
        end
        REG_PPUSCROLL: begin
          if (!w_q) begin
            t_d[COARSE_X_MSB:COARSE_X_LSB] = in_reg_wdata[7:3];
            x_d                            = in_reg_wdata[2:0];
            w_d                            = 1'b1;
          end else begin
            t_d[FINE_Y_MSB:FINE_Y_LSB]     = in_reg_wdata[2:0];
            t_d[COARSE_Y_MSB:COARSE_Y_LSB] = in_reg_wdata[7:3];
            w_d                            = 1'b0;
          end
        end
        REG_PPUADDR: begin
          if (!w_q) begin
            t_d[ADDR_HI_MSB:ADDR_HI_LSB] = in_reg_wdata[5:0];
            t_d[FINE_Y_MSB]              = 1'b0;
            w_d                          = 1'b1;
          end else begin
            t_d[ADDR_LO_MSB:0] = in_reg_wdata;
            load_v             = 1'b1;
            w_d                = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (in_reg_rd && (in_reg_addr == REG_PPUSTATUS)) begin
      w_d = 1'b0;
    end
  end

  // v priority: $2006 second write, then rendering events, then $2007 stepping.
  always_comb begin
    v_d = v_q;
    if (load_v) begin
      v_d = t_d;
    end else if (evt_cx || evt_y || evt_hcopy || evt_vcopy) begin
      if (evt_cx) v_d = inc_coarse_x(v_d);
      if (evt_y)  v_d = inc_fine_y(v_d);
      if (evt_hcopy) begin
        v_d[NT_X_BIT]                  = t_q[NT_X_BIT];
        v_d[COARSE_X_MSB:COARSE_X_LSB] = t_q[COARSE_X_MSB:COARSE_X_LSB];
      end
      if (evt_vcopy) begin
        v_d[FINE_Y_MSB:NT_Y_BIT]       = t_q[FINE_Y_MSB:NT_Y_BIT];
        v_d[COARSE_Y_MSB:COARSE_Y_LSB] = t_q[COARSE_Y_MSB:COARSE_Y_LSB];
      end
    end else if (data_acc) begin
      if (render_active) v_d = inc_fine_y(inc_coarse_x(v_q));
      else               v_d = v_q + (inc32_q ? 15'd32 : 15'd1);
    end
  end

  // Flag is updated on dot 0 so it reads set/clear exactly from dot 1 onwards.
  always_comb begin
    vblank_d = vblank_q;
    if ((scanline == VBL_LINE) && (dot == 9'd0))  vblank_d = 1'b1;
    else if (on_pre && (dot == 9'd0))             vblank_d = 1'b0;
  end

  always_ff @(posedge in_ppu_pixel_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      v_q      <= '0;
      t_q      <= '0;
      x_q      <= 3'd0;
      w_q      <= 1'b0;
      inc32_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      v_q      <= v_d;
      t_q      <= t_d;
      x_q      <= x_d;
      w_q      <= w_d;
      inc32_q  <= inc32_d;
      vblank_q <= vblank_d;
    end
  end

  assign out_dot            = dot;
  assign out_scanline       = scanline;
  assign out_vram_addr      = v_q;
  assign out_vram_addr_temp = t_q;
  assign out_fine_x         = x_q;
  assign out_w              = w_q;
  assign out_vblank         = vblank_q;
  assign out_vblank_start   = (scanline == VBL_LINE) && (dot == 9'd1);
  assign out_frame_odd      = frame_odd;

endmodule

// File: doc/mod_ppu_scroll_timing.md
MOD_PPU_SCROLL_TIMING -- requirements
Module: mod_ppu_scroll_timing

Interface
REQ-001 The block SHALL have parameter DOTS_PER_LINE, default 341, giving dots per scanline.
REQ-002 The block SHALL have parameter LINES_PER_FRAME, default 262 (NTSC; 312 for PAL), giving scanlines per frame; the pre-render line is LINES_PER_FRAME-1.
REQ-003 The block SHALL have parameter VBLANK_LINE, default 241, giving the scanline on which vblank starts.
REQ-004 The block SHALL have parameter ODD_FRAME_SKIP, default 1, which enables the odd-frame dot skip (0 for PAL).
REQ-005 The block SHALL have port in_ppu_pixel_clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port in_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port in_reg_wr, input, 1 bit: single-cycle CPU register-write strobe.
REQ-008 The block SHALL have port in_reg_rd, input, 1 bit: single-cycle CPU register-read strobe.
REQ-009 The block SHALL have port in_reg_addr, input, 3 bits: register index, $2000+n.
REQ-010 The block SHALL have port in_reg_wdata, input, 8 bits: write data.
REQ-011 The block SHALL have port in_rendering_en, input, 1 bit: PPUMASK bit3 OR bit4.
REQ-012 The block SHALL have outputs out_dot (9 bits) and out_scanline (9 bits): the current beam position.
REQ-013 The block SHALL have outputs out_vram_addr (15 bits, v), out_vram_addr_temp (15 bits, t), out_fine_x (3 bits, x) and out_w (1 bit, write toggle).
REQ-014 The block SHALL have outputs out_vblank (1 bit, level), out_vblank_start (1 bit, one-cycle pulse) and out_frame_odd (1 bit).

Function
REQ-015 out_dot SHALL count 0..DOTS_PER_LINE-1; at wrap, out_scanline SHALL increment, wrapping from LINES_PER_FRAME-1 to 0.
REQ-016 out_frame_odd SHALL toggle when out_scanline wraps to 0.
REQ-017 With ODD_FRAME_SKIP=1, the pre-render line, out_frame_odd=1 and in_rendering_en=1, dot DOTS_PER_LINE-2 SHALL be followed directly by scanline 0, dot 0.
REQ-018 At (VBLANK_LINE, dot 1), out_vblank SHALL set and out_vblank_start SHALL pulse for exactly one cycle; out_vblank SHALL clear at (pre-render line, dot 1).
REQ-019 A write to $2000 SHALL load t[11:10]=d[1:0] and store the increment mode inc32=d[2].
REQ-020 A read of $2002 SHALL clear w.
REQ-021 A write to $2005 with w=0 SHALL load t[4:0]=d[7:3] and x=d[2:0], and set w=1.
REQ-022 A write to $2005 with w=1 SHALL load t[14:12]=d[2:0] and t[9:5]=d[7:3], and clear w.
REQ-023 A write to $2006 with w=0 SHALL load t[13:8]=d[5:0] and t[14]=0, and set w=1.
REQ-024 A write to $2006 with w=1 SHALL load t[7:0]=d, set v to the new t in the same cycle, and clear w.
REQ-025 A read or write of $2007 outside active rendering SHALL add 32 (inc32=1) or 1 to v, modulo 2^15.
REQ-026 Active rendering SHALL be defined as in_rendering_en=1 AND (scanline 0..239 OR the pre-render line).
REQ-027 A $2007 access during active rendering SHALL perform a coarse-X increment and a Y increment together.
REQ-028 During active rendering at dots 8,16,...,256,328,336, v SHALL take a coarse-X increment: 31 wraps to 0 and toggles v[10].
REQ-029 During active rendering at dot 256, v SHALL take a Y increment: fine Y below 7 increments; otherwise fine Y goes to 0 and coarse Y goes 29->0 with v[11] toggled, 31->0 with no toggle, else +1.
REQ-030 During active rendering at dot 257, v[10] and v[4:0] SHALL be copied from t.
REQ-031 On the pre-render line at dots 280..304 with rendering enabled, v[14:11] and v[9:5] SHALL be copied from t.
REQ-032 Priority on v SHALL be: second $2006 write > rendering events > $2007 increment.
REQ-033 If in_reg_wr and in_reg_rd are asserted together, the write SHALL be taken and the read ignored.
REQ-034 Writes to other register indices SHALL leave v, t, x and w unchanged.
REQ-035 All register effects SHALL be visible on the outputs one cycle after the strobe.

Reset
REQ-036 While in_rst_n=0, all outputs and internal state SHALL be 0, including dot, scanline, v, t, x, w, inc32, vblank and frame_odd.
REQ-037 Assertion of reset mid-frame or mid-write-pair SHALL abort immediately; after release, counting SHALL restart at (0,0) with w=0.

Structure
REQ-038 Register indices, NTSC/PAL default constants and the v/t bit-field positions SHALL reside in the shared package mod_ppu_pkg.
REQ-039 The dot/scanline counter with its odd-frame skip SHALL be the single sub-module mod_ppu_video_timing.

Verification
REQ-040 Write $2006=0x21 then 0x08 -> t=v=0x2108 and w=0; then a $2007 write with inc32=1 -> v=0x2128.
REQ-041 Write $2005=0x7D then 0x5E -> x=5, t[4:0]=15, t[9:5]=11, t[14:12]=6; a $2002 read between the two writes -> the second write is treated as a first write.
REQ-042 Rendering enabled, v=0x001F at scanline 10 dot 8 -> v=0x0400; fine Y=7 with coarse Y=29 at dot 256 -> fine Y=0, coarse Y=0, v[11] toggled.
REQ-043 NTSC defaults with rendering on -> an odd frame lasts 89341 cycles and an even frame 89342; with rendering off, every frame lasts 89342.
REQ-044 Free run -> out_vblank_start high for 1 cycle at (241,1) and out_vblank low again at (261,1); with LINES_PER_FRAME=312 and ODD_FRAME_SKIP=0, every frame lasts 106392 cycles.
REQ-045 in_rst_n pulsed low between the two $2006 writes -> w=0 and v=0; the next $2006 write acts as a first write.
